// File: rtl/ternary_mvm_stream_if.sv
// ternary_mvm_stream_if
// Handshake bundle for the streaming ternary matrix-vector multiplier.
//   Input stream : in_valid/in_ready, in_data (LANES signed elements),
//                  in_w (LANES x OUT_LEN 2-bit ternary codes).
//   Output stream: out_valid/out_ready, out_data, out_idx, out_last.
//   Status       : busy.
// Modports: master = stream producer/consumer (testbench or upstream),
//           slave  = the multiplier.
`timescale 1ns/1ps

interface ternary_mvm_stream_if #(
  parameter int OUT_LEN   = 7,
  parameter int BIT_WIDTH = 8,
  parameter int LANES     = 2
);
  localparam int IDX_W = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;

  logic                         in_valid;
  logic                         in_ready;
  logic [LANES*BIT_WIDTH-1:0]   in_data;
  logic [LANES*2*OUT_LEN-1:0]   in_w;
  logic                         out_valid;
  logic                         out_ready;
  logic [BIT_WIDTH-1:0]         out_data;
  logic [IDX_W-1:0]             out_idx;
  logic                         out_last;
  logic                         busy;

  modport master (
    output in_valid, in_data, in_w, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, busy
  );

  modport slave (
    input  in_valid, in_data, in_w, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, busy
  );
endinterface

// File: rtl/ternary_mvm_stream.sv
// ternary_mvm_stream
// Streaming ternary matrix-vector multiplier. Each accepted beat carries
// LANES signed input elements plus their ternary weight rows; OUT_LEN wide
// accumulators build the dot products over IN_LEN/LANES beats. The final sums
// land in a double buffer that drains one element per output handshake while
// the next vector accumulates.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - ternary_mvm_stream_if.slave (input/output streams and busy)
// Weight code: bit1 -> -x, else bit0 -> +x, else 0.
// Optional feature: define TERNARY_MVM_SAT_EN to clamp outputs to the signed
// BIT_WIDTH range; otherwise outputs are the low BIT_WIDTH accumulator bits.
`timescale 1ns/1ps

module ternary_mvm_stream #(
  parameter int IN_LEN    = 14,
  parameter int OUT_LEN   = 7,
  parameter int BIT_WIDTH = 8,
  parameter int LANES     = 2,
  parameter int ACC_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ternary_mvm_stream_if.slave   bus
);
  localparam int BEATS  = IN_LEN / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W  = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(OUT_LEN - 1);

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  acc_t              acc      [OUT_LEN];
  acc_t              obuf     [OUT_LEN];
  acc_t              next_sum [OUT_LEN];
  logic [BEAT_W-1:0] beat_cnt;
  logic [IDX_W-1:0]  drain_idx;
  logic              obuf_full;

  logic last_beat;
  logic out_last_w;
  logic out_fire;
  logic in_fire;

  // Narrow an accumulator to the output element width.
  function automatic logic [BIT_WIDTH-1:0] to_out(input acc_t a);
`ifdef TERNARY_MVM_SAT_EN
    acc_t sat_max;
    acc_t sat_min;
    sat_max = ACC_WIDTH'((1 << (BIT_WIDTH - 1)) - 1);
    sat_min = ACC_WIDTH'(-(1 << (BIT_WIDTH - 1)));
    if (a > sat_max)      return sat_max[BIT_WIDTH-1:0];
    else if (a < sat_min) return sat_min[BIT_WIDTH-1:0];
    else                  return a[BIT_WIDTH-1:0];
`else
    return a[BIT_WIDTH-1:0];
`endif
  endfunction

  // Per-column sum of this beat's lane terms, seeded either from zero (first
  // beat drops the previous vector's sums) or from the running accumulator.
  always_comb begin : beat_math
    acc_t       sum;
    acc_t       x;
    logic [1:0] code;
    // NOTE: every variable written here gets a value before any branch so
    // no path leaves it unassigned, which would otherwise infer a latch.
    sum  = '0;
    x    = '0;
    code = '0;
    for (int c = 0; c < OUT_LEN; c++) begin
      sum = (beat_cnt == '0) ? acc_t'('0) : acc[c];
      for (int k = 0; k < LANES; k++) begin
        x    = {{(ACC_WIDTH-BIT_WIDTH){bus.in_data[k*BIT_WIDTH+BIT_WIDTH-1]}},
                bus.in_data[k*BIT_WIDTH +: BIT_WIDTH]};
        code = bus.in_w[(k*OUT_LEN+c)*2 +: 2];
        if (code[1])      sum = sum - x;
        else if (code[0]) sum = sum + x;
      end
      next_sum[c] = sum;
    end
  end

  assign last_beat  = (beat_cnt == LAST_BEAT);
  assign out_last_w = obuf_full && (drain_idx == LAST_IDX);
  assign out_fire   = obuf_full && bus.out_ready;
  // Only the closing beat needs a free buffer; a final drain in the same
  // cycle frees it in time.
  assign bus.in_ready = !(last_beat && obuf_full && !(out_fire && out_last_w));
  assign in_fire      = bus.in_valid && bus.in_ready;

  assign bus.out_valid = obuf_full;
  assign bus.out_data  = obuf_full ? to_out(obuf[drain_idx]) : '0;
  assign bus.out_idx   = drain_idx;
  assign bus.out_last  = out_last_w;
  assign bus.busy      = (beat_cnt != '0) || obuf_full;

  // NOTE: state updates use non-blocking assignments so every register reads
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      drain_idx <= '0;
      obuf_full <= 1'b0;
      // NOTE: the accumulator and output arrays are reset as well so a reset
      // mid-vector leaves no residue visible anywhere.
      for (int c = 0; c < OUT_LEN; c++) begin
        acc[c]  <= '0;
        obuf[c] <= '0;
      end
    end else begin
      if (out_fire) begin
        if (out_last_w) begin
          drain_idx <= '0;
          obuf_full <= 1'b0;
        end else begin
          drain_idx <= drain_idx + IDX_W'(1);
        end
      end
      // Placed after the drain so a refill in the final-drain cycle wins.
      if (in_fire) begin
        for (int c = 0; c < OUT_LEN; c++) acc[c] <= next_sum[c];
        if (last_beat) begin
          beat_cnt  <= '0;
          obuf_full <= 1'b1;
          for (int c = 0; c < OUT_LEN; c++) obuf[c] <= next_sum[c];
        end else begin
          beat_cnt <= beat_cnt + BEAT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_ternary_mvm_stream.sv
// tb_ternary_mvm_stream
// Self-checking bench for ternary_mvm_stream at default parameters
// (14 inputs, 7 outputs, 2 lanes, 7 beats per vector). Expected output
// elements are pushed to a scoreboard queue when the closing beat is driven
// and popped by a monitor on every output handshake.
`timescale 1ns/1ps

module tb_ternary_mvm_stream;
  localparam int IN_LEN = 14, OUT_LEN = 7, BW = 8, LANES = 2, ACCW = 12;
  localparam int BEATS = IN_LEN / LANES;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] idx;
    logic       last;
  } out_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  out_t sb[$];

  logic [LANES*BW-1:0]        vec_d [BEATS];
  logic [LANES*2*OUT_LEN-1:0] vec_w [BEATS];

  ternary_mvm_stream_if #(.OUT_LEN(OUT_LEN), .BIT_WIDTH(BW), .LANES(LANES)) bus ();

  ternary_mvm_stream #(
    .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .BIT_WIDTH(BW), .LANES(LANES), .ACC_WIDTH(ACCW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: compare each consumed element with the queue head.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      out_t got;
      out_t exp;
      got = '{data: bus.out_data, idx: bus.out_idx, last: bus.out_last};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected got data=%h idx=%0d last=%b want nothing", got.data, got.idx, got.last);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          bad++;
          $display("FAIL out_elem got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                   got.data, got.idx, got.last, exp.data, exp.idx, exp.last);
        end
      end
    end
  end

  task automatic push_exp(input int c, input logic [7:0] v);
    sb.push_back('{data: v, idx: 3'(c), last: (c == OUT_LEN-1)});
  endtask

  // Reference model of the current vec_d/vec_w vector.
  task automatic push_model();
    int s;
    logic signed [7:0]  x;
    logic [1:0]         code;
    logic signed [11:0] a;
    logic [7:0]         v;
    for (int c = 0; c < OUT_LEN; c++) begin
      s = 0;
      for (int b = 0; b < BEATS; b++) begin
        for (int k = 0; k < LANES; k++) begin
          x    = vec_d[b][k*BW +: BW];
          code = vec_w[b][(k*OUT_LEN+c)*2 +: 2];
          if (code[1])      s = s - int'(x);
          else if (code[0]) s = s + int'(x);
        end
      end
      a = s[11:0];
`ifdef TERNARY_MVM_SAT_EN
      if (a > 12'sd127)       v = 8'h7F;
      else if (a < -12'sd128) v = 8'h80;
      else                    v = a[7:0];
`else
      v = a[7:0];
`endif
      push_exp(c, v);
    end
  endtask

  task automatic fill_random();
    for (int b = 0; b < BEATS; b++) begin
      vec_d[b] = 16'($urandom);
      vec_w[b] = 28'($urandom);
    end
  endtask

  // Drive one beat and hold it until accepted; stalls counts waiting cycles.
  task automatic send_beat(input int b, input bit use_model, output int stalls);
    bit acc;
    stalls = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = vec_d[b];
    bus.in_w     = vec_w[b];
    if (b == BEATS-1 && use_model) push_model();
    acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (!acc) begin
        stalls++;
        if (stalls > 200) begin
          total++;
          bad++;
          $display("FAIL beat_accept_timeout beat=%0d got in_ready=0 want 1 within 200 cycles", b);
          bus.in_valid = 1'b0;
          return;
        end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_vector(input bit gap, input bit use_model, output int stalls);
    int s;
    stalls = 0;
    for (int b = 0; b < BEATS; b++) begin
      send_beat(b, use_model, s);
      stalls += s;
      if (gap && b < BEATS-1) begin
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b1) begin
          bad++;
          $display("FAIL gap_busy beat=%0d got busy=%b want 1", b, bus.busy);
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [14:0] got;
    got = {bus.in_ready, bus.out_valid, bus.out_data, bus.out_idx, bus.out_last, bus.busy};
    total++;
    if (got !== {1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL %s got rdy=%b vld=%b data=%h idx=%0d last=%b busy=%b want 1 0 00 0 0 0",
               tag, bus.in_ready, bus.out_valid, bus.out_data, bus.out_idx, bus.out_last, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    check_reset_outputs("reset_state");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_all_ones();
    int s;
    bus.out_ready = 1'b1;
    for (int b = 0; b < BEATS; b++) begin
      vec_d[b] = {8'd1, 8'd1};
      vec_w[b] = {(LANES*OUT_LEN){2'b01}};
    end
    for (int c = 0; c < OUT_LEN; c++) push_exp(c, 8'd14);
    send_vector(1'b0, 1'b0, s);
    // Visible one cycle after the closing beat's edge.
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd0) begin
      bad++;
      $display("FAIL latency got out_valid=%b idx=%0d want 1 0", bus.out_valid, bus.out_idx);
    end
    wait_drain();
  endtask

  task automatic test_overflow();
    int s;
    bus.out_ready = 1'b1;
    for (int b = 0; b < BEATS; b++) begin
      vec_d[b] = {8'd100, 8'd100};
      vec_w[b] = {(LANES*OUT_LEN){2'b10}};
    end
`ifdef TERNARY_MVM_SAT_EN
    for (int c = 0; c < OUT_LEN; c++) push_exp(c, 8'h80);
`else
    for (int c = 0; c < OUT_LEN; c++) push_exp(c, 8'h88);
`endif
    send_vector(1'b0, 1'b0, s);
    wait_drain();
  endtask

  task automatic test_weight_codes();
    int s;
    logic [27:0] w;
    bus.out_ready = 1'b1;
    w = '0;
    w[1:0]   = 2'b11;  // lane0 col0
    w[3:2]   = 2'b01;  // lane0 col1
    w[15:14] = 2'b00;  // lane1 col0
    w[17:16] = 2'b01;  // lane1 col1
    for (int b = 0; b < BEATS; b++) begin
      vec_d[b] = {8'hFD, 8'h05};
      vec_w[b] = w;
    end
    push_exp(0, 8'hDD);  // -35
    push_exp(1, 8'd14);
    for (int c = 2; c < OUT_LEN; c++) push_exp(c, 8'h00);
    send_vector(1'b0, 1'b0, s);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int s;
    int stalls = 0;
    bus.out_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      fill_random();
      send_vector(1'b0, 1'b1, s);
      stalls += s;
    end
    total++;
    if (stalls != 0) begin
      bad++;
      $display("FAIL b2b_stalls got %0d want 0", stalls);
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    int s;
    int stalls = 0;
    bit seen_last = 1'b0;
    bus.out_ready = 1'b0;
    fill_random();
    send_vector(1'b0, 1'b1, s);      // vector A fills the buffer
    fill_random();                    // vector B
    for (int b = 0; b < BEATS-1; b++) begin
      send_beat(b, 1'b0, s);
      stalls += s;
    end
    total++;
    if (stalls != 0) begin
      bad++;
      $display("FAIL bp_first_beats stalls got %0d want 0", stalls);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = vec_d[BEATS-1];
    bus.in_w     = vec_w[BEATS-1];
    push_model();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== sb[0].data) begin
        bad++;
        $display("FAIL bp_stall got rdy=%b vld=%b data=%h want 0 1 %h",
                 bus.in_ready, bus.out_valid, bus.out_data, sb[0].data);
      end
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && !seen_last; i++) begin
      @(negedge clk);
      total++;
      if (bus.out_last) begin
        seen_last = 1'b1;
        if (bus.in_ready !== 1'b1) begin
          bad++;
          $display("FAIL bp_last_accept got in_ready=%b want 1", bus.in_ready);
        end
      end else if (bus.in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_wait got in_ready=%b want 0", bus.in_ready);
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    total++;
    if (!seen_last) begin
      bad++;
      $display("FAIL bp_out_last got none want out_last within 20 cycles");
    end
    wait_drain();
  endtask

  task automatic test_mid_reset();
    int s;
    bus.out_ready = 1'b0;
    fill_random();
    send_vector(1'b0, 1'b1, s);
    fill_random();
    for (int b = 0; b < 3; b++) send_beat(b, 1'b0, s);
    total++;
    if (bus.busy !== 1'b1 || bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset got busy=%b vld=%b want 1 1", bus.busy, bus.out_valid);
    end
    rst_n = 1'b0;
    #2;
    check_reset_outputs("mid_reset");
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("post_reset");
    test_all_ones();
  endtask

  task automatic test_gapped();
    int s;
    bus.out_ready = 1'b1;
    fill_random();
    send_vector(1'b1, 1'b1, s);
    wait_drain();
    send_vector(1'b0, 1'b1, s);
    wait_drain();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_w      = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_all_ones();
    test_overflow();
    test_weight_codes();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    test_gapped();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish before 500us");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/ternary_mvm_stream.md
# ternary_mvm_stream

Streaming ternary matrix-vector multiplier: accepts an input vector of `IN_LEN` signed elements, `LANES` elements per beat, with matching ternary weight slices. It accumulates `OUT_LEN` dot products in wide accumulators, then drains the results one element per handshake. This is the parametrised successor of the fixed 14×7, two-row tiny-ternary multiplier. It adds:
- valid/ready flow control on both sides;
- double buffering, so vector N+1 accumulates while vector N drains;
- optional output saturation.

## Interface
Parameters:
- `IN_LEN`, 14: input vector length. Must be divisible by `LANES`.
- `OUT_LEN`, 7: number of output elements, equal to weight columns.
- `BIT_WIDTH`, 8: signed width of input and output elements.
- `LANES`, 2: input elements consumed per beat.
- `ACC_WIDTH`, 12: signed accumulator width. Must be at least `BIT_WIDTH+$clog2(IN_LEN)`.

Ports:
- `clk`, input, 1: clock; all state is rising-edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `in_valid`, input, 1: beat valid.
- `in_ready`, output, 1: beat accepted when `in_valid && in_ready` at a clock edge.
- `in_data`, input, `LANES*BIT_WIDTH`: lane k is `[k*BIT_WIDTH +: BIT_WIDTH]`, signed.
- `in_w`, input, `LANES*2*OUT_LEN`: for lane k, column c, the code is `in_w[(k*OUT_LEN+c)*2 +: 2]`.
- `out_valid`, output, 1: `out_data` is valid.
- `out_ready`, input, 1: output element consumed when `out_valid && out_ready`.
- `out_data`, output, `BIT_WIDTH`: signed result for column `out_idx`.
- `out_idx`, output, `$clog2(OUT_LEN)`: column index of `out_data`.
- `out_last`, output, 1: high with the element for column `OUT_LEN-1`.
- `busy`, output, 1: high when a vector is partially accumulated or the output buffer is occupied.

## Operation
Weight codes, per 2-bit code: bit1 set means −x; else bit0 set means +x; else 0. Code `2'b11` is therefore −x.

Per-column update for a beat:
- Each lane's signed x is sign-extended to `ACC_WIDTH`.
- For each column, the `LANES` lane terms are summed.
- On the first beat of a vector (`beat_cnt==0`), the accumulator loads the beat sum and discards prior contents.
- On later beats, the accumulator adds the beat sum, wrapping at `ACC_WIDTH` bits.

Accumulation side:
- `beat_cnt` counts 0 .. `IN_LEN/LANES-1` and wraps to 0 after the last beat.
- On the last beat, the final sums (accumulator plus that beat's contribution) are written into the output buffer, and `obuf_full` is set.

Drain side:
- While `obuf_full`: `out_valid=1` and `out_data` is `obuf[drain_idx]` converted to `BIT_WIDTH` (see Configuration).
- Each output handshake increments `drain_idx`.
- The handshake with `out_last` clears `obuf_full` and sets `drain_idx` to 0.

Input-side readiness:
- `in_ready = !(beat_cnt==IN_LEN/LANES-1 && obuf_full && !(out_valid && out_ready && out_last))`.
- Only the last beat stalls. A same-cycle final drain handshake frees the buffer, so the last beat is accepted in that cycle.

Other rules:
- `busy = (beat_cnt!=0) || obuf_full`.
- Reset mid-operation discards partial sums and buffered results. No stale `out_valid` appears after reset.

## Timing
Reset values:
- `in_ready`=1.
- `out_valid`=0, `out_data`=0, `out_idx`=0, `out_last`=0, `busy`=0.
- All internal counters and accumulators are 0.

Latency: `out_valid` rises on the edge that accepts the last beat, i.e. it is visible in the following cycle.

Throughput:
- With `out_ready` held high, sustained rate is one beat per cycle, provided `OUT_LEN <= IN_LEN/LANES`.
- Otherwise, the input stalls for `OUT_LEN - IN_LEN/LANES` cycles per vector.

Output outputs: `out_data`, `out_idx`, `out_last` are combinational from registered `obuf` and `drain_idx`. They are stable while `out_valid && !out_ready`.

`in_valid` may drop between beats. Partial state is held indefinitely.

## Configuration
Macro `TERNARY_MVM_SAT_EN`:
- Defined: the output conversion clamps the accumulator to the signed `BIT_WIDTH` range, [−2^(BIT_WIDTH−1), 2^(BIT_WIDTH−1)−1].
- Undefined: the output is the low `BIT_WIDTH` bits of the accumulator (two's-complement wrap).
- Accumulation itself always wraps at `ACC_WIDTH`, regardless of the macro.

## Test plan
Defaults are used throughout (7 beats per vector).
- **All +1:** all weights `01`, all inputs 1, `out_ready`=1 → outputs 14 for `out_idx` 0..6, with `out_last` only at idx 6.
- **Overflow:** all weights `10`, inputs 100 → accumulator −1400. Output is −128 (`0x80`) with `TERNARY_MVM_SAT_EN`, and `0x88` without.
- **Weight codes:** lane0 = 5, lane1 = −3; column 0 code pair (`11`, `00`), column 1 code pair (`01`, `01`); repeated over 7 beats → column 0 = −35, column 1 = 14.
- **Backpressure:** hold `out_ready`=0 after vector A completes and stream vector B → 6 beats accepted, then `in_ready`=0. Raise `out_ready` → 7 drains of A; B's last beat is accepted on A's `out_last` cycle, then B drains correctly.
- **Mid-vector reset:** assert `rst_n`=0 after 3 beats → all outputs return to reset values. The next full vector yields a clean result with no residue.
- **Gapped input:** `in_valid` toggled 1-0-1 every cycle → results identical to the gapless case, and `busy` stays high between beats.
